flipper_bank: RTL and testbench

//  N-channel flipper motion controller; generalised successor to the single-speed left/right flip block.

---
 rtl/flipper_bank.sv | 108 ++++++++++
 tb/tb_flipper_bank.sv | 96 +++++++++
 2 files changed

// File: rtl/flipper_bank.sv
// flipper_bank: N-channel flipper motion controller (ports: clk, rst, enable, btn[N] in; pos_y[N*POS_W], at_top[N], moving[N], swing_start[N] out)
module flipper_bank #(
  parameter int N_FLIP    = 2,
  parameter int POS_W     = 10,
  parameter int REST_Y    = 290,
  parameter int TOP_Y     = 270,
  parameter int RISE_DIV  = 199999,
  parameter int FALL_DIV  = 1999999,
  parameter int RISE_STEP = 2,
  parameter int FALL_STEP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_FLIP-1:0]       btn,
  output logic [N_FLIP*POS_W-1:0] pos_y,
  output logic [N_FLIP-1:0]       at_top,
  output logic [N_FLIP-1:0]       moving,
  output logic [N_FLIP-1:0]       swing_start
);
  localparam int RW = $clog2(RISE_DIV + 2);
  localparam int FW = $clog2(FALL_DIV + 2);
  localparam logic [POS_W-1:0] REST_P = POS_W'(REST_Y);
  localparam logic [POS_W-1:0] TOP_P  = POS_W'(TOP_Y);
  localparam logic [POS_W-1:0] RS_P   = POS_W'(RISE_STEP);
  localparam logic [POS_W-1:0] FS_P   = POS_W'(FALL_STEP);
  typedef enum logic [1:0] {REST, RISE, HOLD, FALL} state_t;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          rise_tick, fall_tick;
  always_comb begin
    rise_tick = enable && rcnt_q == RW'(RISE_DIV);
    fall_tick = enable && fcnt_q == FW'(FALL_DIV);
    rcnt_d    = !enable ? rcnt_q : rise_tick ? '0 : rcnt_q + 1'b1;
    fcnt_d    = !enable ? fcnt_q : fall_tick ? '0 : fcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      fcnt_q <= fcnt_d;
    end
  end
  genvar i;
  for (i = 0; i < N_FLIP; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             sw_q, sw_d;
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= REST;
        pos_q   <= REST_P;
        sw_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        pos_q   <= pos_d;
        sw_q    <= sw_d;
      end
    end
    // Limits are compared before stepping so pos never wraps past TOP_Y/REST_Y.
    always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      sw_d    = 1'b0;
      if (enable) begin
        case (state_q)
          REST: begin
            pos_d = REST_P;
            if (btn[i]) begin
              state_d = RISE;
              sw_d    = 1'b1;
            end
          end
          RISE: begin
            if (!btn[i]) state_d = FALL;
            else if (rise_tick) begin
              if (int'(pos_q) <= TOP_Y + RISE_STEP) begin
                pos_d   = TOP_P;
                state_d = HOLD;
              end else pos_d = pos_q - RS_P;
            end
          end
          HOLD: begin
            pos_d = TOP_P;
            if (!btn[i]) state_d = FALL;
          end
          default: begin
            if (btn[i]) begin
              state_d = RISE;
              sw_d    = 1'b1;
            end else if (fall_tick) begin
              if (int'(pos_q) + FALL_STEP >= REST_Y) begin
                pos_d   = REST_P;
                state_d = REST;
              end else pos_d = pos_q + FS_P;
            end
          end
        endcase
      end
    end
    assign pos_y[i*POS_W +: POS_W] = pos_q;
    assign at_top[i]               = state_q == HOLD;
    assign moving[i]               = state_q == RISE || state_q == FALL;
    assign swing_start[i]          = sw_q;
  end
endmodule

// File: tb/tb_flipper_bank.sv
// tb_flipper_bank: directed vector bench for flipper_bank
module tb_flipper_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] btn = 2'b00;
  logic [15:0] pos_y;
  logic [1:0] at_top, moving, swing_start;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic       r;
    logic       en;
    logic [1:0] b;
    int         rep;
    logic [7:0] p0;
    logic [7:0] p1;
    logic [1:0] top;
    logic [1:0] mov;
    logic [1:0] sw;
  } vec_t;
  vec_t tbl[$];
  flipper_bank #(
    .N_FLIP(2), .POS_W(8), .REST_Y(20), .TOP_Y(10),
    .RISE_DIV(1), .FALL_DIV(3), .RISE_STEP(3), .FALL_STEP(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .btn(btn),
    .pos_y(pos_y), .at_top(at_top), .moving(moving), .swing_start(swing_start)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic en, input logic [1:0] b, input int rep,
                     input logic [7:0] p0, input logic [7:0] p1,
                     input logic [1:0] top, input logic [1:0] mov, input logic [1:0] sw);
    vec_t v;
    v = '{r, en, b, rep, p0, p1, top, mov, sw};
    tbl.push_back(v);
  endtask
  task automatic step(input string name, input logic r, input logic en, input logic [1:0] b,
                      input logic [7:0] p0, input logic [7:0] p1,
                      input logic [1:0] top, input logic [1:0] mov, input logic [1:0] sw);
    rst = r;
    enable = en;
    btn = b;
    @(posedge clk);
    #1;
    vectors++;
    if (pos_y !== {p1, p0} || at_top !== top || moving !== mov || swing_start !== sw) begin
      miscompares++;
      $display("FAIL %s t=%0t: pos1=%0d pos0=%0d top=%b mov=%b sw=%b, want pos1=%0d pos0=%0d top=%b mov=%b sw=%b",
               name, $time, pos_y[15:8], pos_y[7:0], at_top, moving, swing_start, p1, p0, top, mov, sw);
    end
  endtask
  initial begin
    add(1, 1, 2'b00,  2, 20, 20, 2'b00, 2'b00, 2'b00);
    add(0, 1, 2'b00, 20, 20, 20, 2'b00, 2'b00, 2'b00);
    add(0, 1, 2'b01,  1, 20, 20, 2'b00, 2'b01, 2'b01);
    add(0, 1, 2'b01,  2, 17, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  2, 14, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  2, 11, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  3, 10, 20, 2'b01, 2'b00, 2'b00);
    add(0, 1, 2'b00,  1, 10, 20, 2'b00, 2'b01, 2'b00);
    for (int k = 11; k <= 19; k++) add(0, 1, 2'b00, 4, 8'(k), 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b00,  5, 20, 20, 2'b00, 2'b00, 2'b00);
    add(0, 1, 2'b01,  1, 20, 20, 2'b00, 2'b01, 2'b01);
    add(0, 1, 2'b01,  2, 17, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  1, 14, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b00,  3, 14, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b00,  4, 15, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b00,  1, 16, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  1, 16, 20, 2'b00, 2'b01, 2'b01);
    add(0, 1, 2'b01,  2, 13, 20, 2'b00, 2'b01, 2'b00);
    add(0, 1, 2'b01,  2, 10, 20, 2'b01, 2'b00, 2'b00);
    add(1, 1, 2'b01,  1, 20, 20, 2'b00, 2'b00, 2'b00);
    add(0, 1, 2'b11,  1, 20, 20, 2'b00, 2'b11, 2'b11);
    add(0, 1, 2'b11,  2, 17, 17, 2'b00, 2'b11, 2'b00);
    add(0, 1, 2'b11,  1, 14, 14, 2'b00, 2'b11, 2'b00);
    add(0, 0, 2'b00, 10, 14, 14, 2'b00, 2'b11, 2'b00);
    add(0, 1, 2'b11,  1, 14, 14, 2'b00, 2'b11, 2'b00);
    add(0, 0, 2'b00,  1, 14, 14, 2'b00, 2'b11, 2'b00);
    add(0, 1, 2'b11,  2, 11, 11, 2'b00, 2'b11, 2'b00);
    add(0, 1, 2'b11,  2, 10, 10, 2'b11, 2'b00, 2'b00);
    foreach (tbl[n])
      for (int k = 0; k < tbl[n].rep; k++)
        step($sformatf("vec%0d.%0d", n, k), tbl[n].r, tbl[n].en, tbl[n].b,
             tbl[n].p0, tbl[n].p1, tbl[n].top, tbl[n].mov, tbl[n].sw);
    step("ch0_release_a", 0, 1, 2'b10, 10, 10, 2'b10, 2'b01, 2'b00);
    step("ch0_release_b", 0, 1, 2'b10, 10, 10, 2'b10, 2'b01, 2'b00);
    step("ch0_fall_tick", 0, 1, 2'b10, 11, 10, 2'b10, 2'b01, 2'b00);
    step("rst_mid_hold",  1, 1, 2'b10, 20, 20, 2'b00, 2'b00, 2'b00);
    step("post_rst_press", 0, 1, 2'b01, 20, 20, 2'b00, 2'b01, 2'b01);
    step("post_rst_tick",  0, 1, 2'b01, 17, 20, 2'b00, 2'b01, 2'b00);
    step("post_rst_idle",  0, 1, 2'b01, 17, 20, 2'b00, 2'b01, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
